// File: rtl/peridot_config_trigger.sv
// peridot_config_trigger: Avalon-MM trigger that pulses ru_nconfig low and watches for the ru_ready acknowledge; define PERIDOT_CFGTRIG_KEY_EN to require key 8'hA5 in CTRL[15:8] for a start
module peridot_config_trigger #(
  parameter int PULSE_DEFAULT     = 100,
  parameter int ACK_TIMEOUT_CYCLE = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        ru_ready,
  input  logic        ru_bootsel,
  input  logic        ru_nstatus,
  output logic        ru_nconfig
);
  typedef enum logic [1:0] {IDLE, ASSERT, WAITACK, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  meta_q, sync_q;
  logic [15:0] pulse_q, pulse_d;
  logic [19:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        nconfig_q, nconfig_d;
  logic        busy, ctrl_wr, key_ok, start, unused_wd;
  assign busy    = state_q != IDLE;
  assign ctrl_wr = avs_write & ~avs_address;
`ifdef PERIDOT_CFGTRIG_KEY_EN
  assign key_ok = avs_writedata[15:8] == 8'hA5;
`else
  assign key_ok = 1'b1;
`endif
  assign start        = ctrl_wr & avs_writedata[0] & key_ok;
  assign unused_wd    = &{1'b0, avs_writedata[31:16]};
  assign ru_nconfig   = nconfig_q;
  assign avs_readdata = ~avs_read ? 32'd0 : avs_address ? {16'd0, pulse_q} : {27'd0, err_q, busy, sync_q};
  // synchronisers and all state registers; nconfig releases asynchronously on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      state_q   <= IDLE;
      pulse_q   <= 16'(PULSE_DEFAULT);
      cnt_q     <= '0;
      err_q     <= 1'b0;
      nconfig_q <= 1'b1;
    end else begin
      meta_q    <= {ru_nstatus, ru_bootsel, ru_ready};
      sync_q    <= meta_q;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      nconfig_q <= nconfig_d;
    end
  end
  // next state: err clear is applied before any set from the FSM in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nconfig_d = nconfig_q;
    err_d     = err_q & ~(ctrl_wr & avs_writedata[4]);
    pulse_d   = (avs_write & avs_address & ~busy) ? (avs_writedata[15:0] == 16'd0 ? 16'd1 : avs_writedata[15:0]) : pulse_q;
    case (state_q)
      IDLE:
        if (start) begin
          if (sync_q[0]) begin
            state_d   = ASSERT;
            cnt_d     = {4'd0, pulse_q};
            err_d     = 1'b0;
            nconfig_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      ASSERT:
        if (cnt_q == 20'd1) begin
          state_d   = WAITACK;
          cnt_d     = 20'(ACK_TIMEOUT_CYCLE);
          nconfig_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      WAITACK:
        if (!sync_q[0]) begin
          state_d = DONE;
        end else if (cnt_q == 20'd0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      default: state_d = state_q;
    endcase
  end
endmodule

// File: tb/tb_peridot_config_trigger.sv
// tb_peridot_config_trigger: directed and random stimulus against a time-based reference model
module tb_peridot_config_trigger;
  localparam int T         = 20;
  localparam int PULSE_DEF = 100;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        avs_address = 1'b0, avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0, avs_readdata;
  logic        ru_ready = 1'b0, ru_bootsel = 1'b0, ru_nstatus = 1'b0, ru_nconfig;
  int          n_checks = 0, n_fail = 0;
  bit          m_active, m_done, m_err;
  int          m_t0, m_pw, m_pulse, k;
  logic [2:0]  hist[$];
  always #5 clk = ~clk;
  peridot_config_trigger #(.PULSE_DEFAULT(PULSE_DEF), .ACK_TIMEOUT_CYCLE(T)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .ru_ready(ru_ready), .ru_bootsel(ru_bootsel), .ru_nstatus(ru_nstatus), .ru_nconfig(ru_nconfig)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask
  // One bus cycle: drive, clock, advance the model, then compare nconfig and readdata.
  task automatic step(bit wr, bit rd, bit adr, logic [31:0] wd);
    logic [2:0]  in;
    logic [31:0] exp_rd;
    bit          rs, busy0, start, exp_n;
    int          e;
    avs_write = wr; avs_read = rd; avs_address = adr; avs_writedata = wd;
    @(posedge clk);
    in = {ru_nstatus, ru_bootsel, ru_ready};
    rs = hist[0][0];
    hist.push_back(in);
    void'(hist.pop_front());
    busy0 = m_active || m_done;
    start = wr && !adr && wd[0];
`ifdef PERIDOT_CFGTRIG_KEY_EN
    start = start && (wd[15:8] == 8'hA5);
`endif
    if (wr && !adr && wd[4]) m_err = 0;
    if (wr && adr && !busy0) m_pulse = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
    if (m_active) begin
      e = k - m_t0;
      if (e > m_pw) begin
        if (!rs) begin m_active = 0; m_done = 1; end
        else if (e - m_pw == T + 1) begin m_active = 0; m_err = 1; end
      end
    end else if (!m_done && start) begin
      if (rs) begin m_active = 1; m_t0 = k; m_pw = m_pulse; m_err = 0; end
      else m_err = 1;
    end
    exp_n  = !(m_active && (k - m_t0) < m_pw);
    exp_rd = !rd ? 32'd0 : adr ? 32'(m_pulse) : {27'd0, m_err, m_active || m_done, hist[0]};
    k++;
    #1;
    chk("nconfig", ru_nconfig, exp_n);
    chk("readdata", avs_readdata, exp_rd);
  endtask
  task automatic wr_ctrl(logic [31:0] wd);  step(1'b1, 1'b0, 1'b0, wd); endtask
  task automatic wr_pulse(logic [31:0] wd); step(1'b1, 1'b0, 1'b1, wd); endtask
  task automatic rd_reg(bit adr);           step(1'b0, 1'b1, adr, 32'd0); endtask
  task automatic do_reset();
    avs_write = 1'b0; avs_read = 1'b1; avs_address = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("reset_nconfig", ru_nconfig, 1);
    chk("reset_ctrl", avs_readdata, 0);
    m_active = 0; m_done = 0; m_err = 0; m_pulse = PULSE_DEF; k = 0;
    hist = '{3'b0, 3'b0};
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic pulse_len(output int n);
    n = 0;
    while (!ru_nconfig && n < 300) begin n++; rd_reg(1'b0); end
  endtask
  initial begin
    int n, r;
    logic [31:0] wd;
    ru_ready = 1'b1; ru_bootsel = 1'b1;
    #2;
    do_reset();
    rd_reg(1'b0);
    rd_reg(1'b0);
    chk("reset_status", avs_readdata, 32'h3);
    rd_reg(1'b1);
    chk("reset_pulse", avs_readdata, PULSE_DEF);
    chk("reset_nconfig_idle", ru_nconfig, 1);
    wr_pulse(32'd5);
    wr_ctrl(32'h0000_A501);
    pulse_len(n);
    chk("pulse_width_5", n, 5);
    repeat (3) rd_reg(1'b0);
    ru_ready = 1'b0;
    repeat (6) rd_reg(1'b0);
    chk("done_busy_noerr", avs_readdata[4:3], 32'b01);
    wr_ctrl(32'h0000_A501);
    repeat (10) rd_reg(1'b0);
    chk("done_sticky", {ru_nconfig, avs_readdata[4:3]}, 32'b101);
    ru_ready = 1'b1;
    do_reset();
    repeat (3) rd_reg(1'b0);
    wr_pulse(32'd2);
    wr_ctrl(32'h0000_A501);
    pulse_len(n);
    chk("pulse_width_2", n, 2);
    n = 0;
    do begin rd_reg(1'b0); n++; end while (avs_readdata[3] && n < 100);
    chk("ack_timeout_cycles", n, T + 1);
    chk("timeout_err", avs_readdata[4:3], 32'b10);
    wr_ctrl(32'h10);
    rd_reg(1'b0);
    chk("err_cleared", avs_readdata[4], 0);
    wr_pulse(32'd6);
    wr_ctrl(32'h0000_A501);
    wr_ctrl(32'h0000_A501);
    wr_pulse(32'd2);
    n = 2;
    while (!ru_nconfig && n < 300) begin n++; rd_reg(1'b0); end
    chk("busy_pulse_width", n, 6);
    rd_reg(1'b1);
    chk("busy_pulse_kept", avs_readdata, 6);
    repeat (T + 4) rd_reg(1'b0);
    wr_pulse(32'd0);
    rd_reg(1'b1);
    chk("zero_pulse_reads_1", avs_readdata, 1);
    wr_ctrl(32'h0000_A511);
    pulse_len(n);
    chk("pulse_width_1", n, 1);
    repeat (T + 4) rd_reg(1'b0);
    ru_ready = 1'b0;
    repeat (3) rd_reg(1'b0);
    wr_ctrl(32'h0000_A511);
    chk("notready_nconfig", ru_nconfig, 1);
    rd_reg(1'b0);
    chk("notready_err", avs_readdata[4:3], 32'b10);
    ru_ready = 1'b1;
    wr_ctrl(32'h10);
    wr_pulse(32'd40);
    repeat (3) rd_reg(1'b0);
    wr_ctrl(32'h1);
`ifdef PERIDOT_CFGTRIG_KEY_EN
    chk("bad_key_no_pulse", ru_nconfig, 1);
    rd_reg(1'b0);
    chk("bad_key_no_err", avs_readdata[4:3], 0);
    wr_ctrl(32'h0000_A501);
`endif
    chk("start_low", ru_nconfig, 0);
    repeat (5) rd_reg(1'b0);
    do_reset();
    rd_reg(1'b0);
    chk("reset_mid_idle", {ru_nconfig, avs_readdata[4:3]}, 32'b100);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(30) == 0) ru_ready = ~ru_ready;
      if ($urandom_range(20) == 0) ru_bootsel = ~ru_bootsel;
      if ($urandom_range(20) == 0) ru_nstatus = ~ru_nstatus;
      if ($urandom_range(400) == 0) do_reset();
      r  = int'($urandom_range(9));
      wd = $urandom;
      if (r < 2) begin
        if ($urandom_range(3) != 0) wd[15:8] = 8'hA5;
        wr_ctrl(wd);
      end else if (r == 2) begin
        wd[15:3] = '0;
        wr_pulse(wd);
      end else begin
        step(1'b0, r < 8, r[0], 32'd0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/peridot_config_trigger.md
# peridot_config_trigger

Host-side trigger stage for the remote-update sequencer in the PERIDOT host bridge. An Avalon-MM slave with two registers lets the host read the synchronised ready/bootsel/nstatus flags and request a reconfiguration. On a request, the block drives `ru_nconfig` low for a programmable number of cycles and then releases it. It then waits for the sequencer to acknowledge the request by dropping `ru_ready`, and flags an error if that does not happen within a timeout.

## Interface

Parameters:
- `PULSE_DEFAULT`, 100: reset value of the pulse-width register, in clocks.
- `ACK_TIMEOUT_CYCLE`, 1000: clocks allowed for `ru_ready` to fall after `ru_nconfig` is released. Must be less than 2^20.

Ports:
- `clk`  in  1: single clock for all logic, up to 80 MHz.
- `reset_n`  in  1: asynchronous, active-low reset.
- `avs_address`  in  1: register select. 0 = CTRL/STATUS, 1 = PULSE.
- `avs_read`  in  1: read strobe.
- `avs_readdata`  out  32: combinational read data, zero wait states.
- `avs_write`  in  1: write strobe.
- `avs_writedata`  in  32: write data.
- `ru_ready`  in  1: async ready from the sequencer.
- `ru_bootsel`  in  1: async boot image indicator (0 = image0, 1 = image1).
- `ru_nstatus`  in  1: async nstatus from the sequencer.
- `ru_nconfig`  out  1: registered reconfiguration request to the sequencer. The sequencer acts on its rising edge.

## Operation

Input synchronisation:
- `ru_ready`, `ru_bootsel` and `ru_nstatus` each pass through a 2-flop synchroniser.
- Reset values: ready 0, bootsel 0, nstatus 0.

CTRL/STATUS register (address 0). Read fields:
- [0] ready_s
- [1] bootsel_s
- [2] nstatus_s
- [3] busy (state is not IDLE)
- [4] err
- [31:5] zero

CTRL/STATUS register writes:
- [0]=1 is a start request, subject to the key check in Configuration.
- [4]=1 clears err (write-1-to-clear).

PULSE register (address 1):
- [15:0] read/write, pulse width in clocks. Reset value `PULSE_DEFAULT`.
- Writing 0 stores 1.
- Writes while busy are ignored.

State machine, reset state IDLE:
- IDLE: on a valid start:
  - If ready_s=1: load the pulse counter from PULSE, clear err, set `ru_nconfig`=0, go to ASSERT.
  - If ready_s=0: set err=1 and stay in IDLE; `ru_nconfig` does not move.
- ASSERT: decrement the pulse counter each clock. When it reaches 1, set `ru_nconfig`=1, load the timeout counter from `ACK_TIMEOUT_CYCLE`, go to WAITACK.
- WAITACK:
  - If ready_s=0: go to DONE.
  - Else if the timeout counter reaches 0: set err=1, go to IDLE.
  - Else decrement the timeout counter.
- DONE: terminal. The device is reconfiguring, busy stays 1, and only reset exits this state.

Boundary conditions:
- Start while busy is ignored; err is unchanged.
- A start and an err clear in the same write are both applied, with the clear first. This means an immediately rejected start still leaves err=1.
- If ready_s falls during ASSERT, the pulse still completes and WAITACK exits on its first cycle.
- Reset mid-operation: `ru_nconfig` goes to 1 asynchronously and the state goes to IDLE. `reset_n` is shared with the sequencer's reset, so the resulting edge is absorbed by the sequencer's own reset.

## Timing

- Reset values: `ru_nconfig`=1, `avs_readdata`=0 when no read is in progress, err=0, PULSE=`PULSE_DEFAULT`.
- `ru_nconfig` falls on the clock edge that samples the start write. It stays low for exactly PULSE clocks.
- Status latency: an input change is visible in CTRL after 2 clocks.
- Acknowledge window: ready_s must fall within `ACK_TIMEOUT_CYCLE`+1 clocks of `ru_nconfig` rising.
- Register updates take effect on the clock edge that samples `avs_write`.

## Configuration

- `PERIDOT_CFGTRIG_KEY_EN` defined:
  - A start is valid only if writedata[15:8]=8'hA5 and [0]=1.
  - A start with the wrong key is ignored and err is left unchanged.
- `PERIDOT_CFGTRIG_KEY_EN` not defined: [0]=1 alone is a valid start, and writedata[15:8] is ignored.

## Test plan

- **Reset defaults:** release reset with ru_ready=1 and bootsel=1. Then CTRL reads 0x03 after 2 clocks plus the read, PULSE reads 100, and `ru_nconfig`=1.
- **Normal trigger:** write PULSE=5, then CTRL=0x0000A501. `ru_nconfig` is low for exactly 5 clocks. Drop ru_ready 3 clocks after release. Busy stays 1, err=0, and the state remains DONE until reset.
- **Timeout:** set `ACK_TIMEOUT_CYCLE`=20 and hold ru_ready=1 after the pulse. err=1 and busy=0 after 21+2 clocks. Writing CTRL=0x10 clears err.
- **Not ready:** with ru_ready=0, a start leaves `ru_nconfig` at 1 and err=1.
- **Busy and zero-width writes:** a second start and a PULSE write during ASSERT are both ignored, and the pulse width is unchanged. A separate write of PULSE=0 reads back 1 and gives a 1-clock pulse.
- **Key and reset checks:**
  - With the key macro defined, writing CTRL=0x00000001 gives no pulse and err=0.
  - Asserting reset mid-ASSERT sets `ru_nconfig`=1 immediately and the state returns to IDLE.
